ps2_mouse_packet: RTL and testbench



---
 rtl/ps2_mouse_pkg.sv | 24 ++
 rtl/ps2_cursor_axis.sv | 42 ++++
 rtl/ps2_mouse_packet.sv | 160 ++++++++++++++++
 tb/tb_ps2_mouse_packet.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_mouse_pkg.sv
// Shared definitions for the PS/2 mouse packet assembler: framing states,
// byte 0 bit positions and the decoded delta width.
package ps2_mouse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B1   = 3'd1,
        ST_B2   = 3'd2,
        ST_B3   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int unsigned BTN_L = 0;
    localparam int unsigned BTN_R = 1;
    localparam int unsigned BTN_M = 2;
    localparam int unsigned SYNC  = 3;
    localparam int unsigned XS    = 4;
    localparam int unsigned YS    = 5;
    localparam int unsigned XO    = 6;
    localparam int unsigned YO    = 7;

    localparam int unsigned DELTA_W = 9;

endpackage

// File: rtl/ps2_cursor_axis.sv
// One cursor axis: signed accumulate of a delta into the position, clamped
// to [0, MAX], updated only when en is high.
module ps2_cursor_axis
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned MAX     = 639,
    parameter int unsigned INIT    = 320,
    parameter int unsigned COORD_W = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic signed [DELTA_W:0]   delta,
    output logic [COORD_W-1:0]        pos
);

    localparam int unsigned SUM_W = COORD_W + 2;
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX);

    logic signed [SUM_W-1:0] sum_c;
    logic [COORD_W-1:0]      clamped_c;

    always_comb begin
        sum_c = $signed({2'b00, pos}) + SUM_W'(delta);
        if (sum_c[SUM_W-1]) begin
            clamped_c = '0;
        end else if (sum_c > MAX_S) begin
            clamped_c = COORD_W'(MAX);
        end else begin
            clamped_c = sum_c[COORD_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= COORD_W'(INIT);
        end else if (en) begin
            pos <= clamped_c;
        end
    end

endmodule

// File: rtl/ps2_mouse_packet.sv
// PS/2 mouse packet framer: assembles 3- or 4-byte packets from the byte
// strobe, decodes buttons/deltas/wheel and tracks a screen-clamped cursor.
module ps2_mouse_packet
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned PACKET_BYTES   = 3,
    parameter int unsigned X_MAX          = 639,
    parameter int unsigned Y_MAX          = 479,
    parameter int unsigned X_INIT         = 320,
    parameter int unsigned Y_INIT         = 240,
    parameter int unsigned COORD_W        = 10,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [7:0]                 received_data,
    input  logic                       received_data_en,
    output logic                       packet_valid,
    output logic [2:0]                 buttons,
    output logic signed [DELTA_W-1:0]  dx,
    output logic signed [DELTA_W-1:0]  dy,
    output logic signed [3:0]          wheel,
    output logic [COORD_W-1:0]         cursor_x,
    output logic [COORD_W-1:0]         cursor_y,
    output logic                       sync_error
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit WHEEL_MODE = (PACKET_BYTES == 4);

    if (PACKET_BYTES != 3 && PACKET_BYTES != 4) begin : g_bad_packet_bytes
        $error("ps2_mouse_packet: PACKET_BYTES must be 3 or 4");
    end

    state_t                     state, state_next;
    logic [CNT_W-1:0]           cnt, cnt_next;
    logic [7:0]                 b0, b1, b2;
    logic                       cap0_c, cap1_c, cap2_c, commit_c, reject_c;
    logic [7:0]                 byte2_c;
    logic signed [DELTA_W-1:0]  dx_c, dy_c;
    logic signed [3:0]          wheel_c;
    logic signed [DELTA_W:0]    dx_ext_c, dy_neg_c;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE behaves like IDLE for an incoming strobe so back-to-back packets lose nothing
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        cap0_c     = 1'b0;
        cap1_c     = 1'b0;
        cap2_c     = 1'b0;
        commit_c   = 1'b0;
        reject_c   = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                state_next = ST_IDLE;
                if (received_data_en) begin
                    if (received_data[SYNC]) begin
                        cap0_c     = 1'b1;
                        state_next = ST_B1;
                    end else begin
                        reject_c = 1'b1;
                    end
                end
            end
            ST_B1, ST_B2, ST_B3: begin
                if (received_data_en) begin
                    if (state == ST_B1) begin
                        cap1_c     = 1'b1;
                        state_next = ST_B2;
                    end else if (state == ST_B2 && WHEEL_MODE) begin
                        cap2_c     = 1'b1;
                        state_next = ST_B3;
                    end else begin
                        commit_c   = 1'b1;
                        state_next = ST_DONE;
                    end
                end else if (cnt == CNT_LAST) begin
                    reject_c   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Decode from captured bytes plus the final byte still on the bus
    always_comb begin
        byte2_c  = WHEEL_MODE ? b2 : received_data;
        dx_c     = b0[XO] ? '0 : {b0[XS], b1};
        dy_c     = b0[YO] ? '0 : {b0[YS], byte2_c};
        wheel_c  = WHEEL_MODE ? received_data[3:0] : '0;
        dx_ext_c = (DELTA_W + 1)'(dx_c);
        dy_neg_c = -((DELTA_W + 1)'(dy_c));
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            b0           <= '0;
            b1           <= '0;
            b2           <= '0;
            packet_valid <= 1'b0;
            sync_error   <= 1'b0;
            buttons      <= '0;
            dx           <= '0;
            dy           <= '0;
            wheel        <= '0;
        end else begin
            cnt          <= cnt_next;
            packet_valid <= commit_c;
            sync_error   <= reject_c;
            if (cap0_c) b0 <= received_data;
            if (cap1_c) b1 <= received_data;
            if (cap2_c) b2 <= received_data;
            if (commit_c) begin
                buttons <= {b0[BTN_M], b0[BTN_R], b0[BTN_L]};
                dx      <= dx_c;
                dy      <= dy_c;
                wheel   <= wheel_c;
            end
        end
    end

    ps2_cursor_axis #(
        .MAX     (X_MAX),
        .INIT    (X_INIT),
        .COORD_W (COORD_W)
    ) u_axis_x (
        .clk   (CLOCK_50),
        .rst   (reset),
        .en    (commit_c),
        .delta (dx_ext_c),
        .pos   (cursor_x)
    );

    // Screen Y grows downward, so the mouse's up-positive dy is subtracted
    ps2_cursor_axis #(
        .MAX     (Y_MAX),
        .INIT    (Y_INIT),
        .COORD_W (COORD_W)
    ) u_axis_y (
        .clk   (CLOCK_50),
        .rst   (reset),
        .en    (commit_c),
        .delta (dy_neg_c),
        .pos   (cursor_y)
    );

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Bench for ps2_mouse_packet: a 3-byte and a 4-byte instance driven by
// directed and random packets, checked against an arithmetic cursor model.
module tb_ps2_mouse_packet;

    localparam int T = 50;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]        d3, d4;
    logic              e3, e4;
    logic              pv3, se3, pv4, se4;
    logic [2:0]        btn3, btn4;
    logic signed [8:0] dx3, dy3, dx4, dy4;
    logic signed [3:0] wh3, wh4;
    logic [9:0]        cx3, cy3, cx4, cy4;

    ps2_mouse_packet #(.PACKET_BYTES(3), .TIMEOUT_CYCLES(T)) u3 (
        .CLOCK_50(clk), .reset(rst), .received_data(d3), .received_data_en(e3),
        .packet_valid(pv3), .buttons(btn3), .dx(dx3), .dy(dy3), .wheel(wh3),
        .cursor_x(cx3), .cursor_y(cy3), .sync_error(se3)
    );

    ps2_mouse_packet #(.PACKET_BYTES(4), .TIMEOUT_CYCLES(T)) u4 (
        .CLOCK_50(clk), .reset(rst), .received_data(d4), .received_data_en(e4),
        .packet_valid(pv4), .buttons(btn4), .dx(dx4), .dy(dy4), .wheel(wh4),
        .cursor_x(cx4), .cursor_y(cy4), .sync_error(se4)
    );

    int checks   = 0;
    int failures = 0;
    int mx[2], my[2], mbtn[2], mdx[2], mdy[2], mwh[2];

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mx[k] = 320; my[k] = 240;
            mbtn[k] = 0; mdx[k] = 0; mdy[k] = 0; mwh[k] = 0;
        end
    endtask

    task automatic model_pkt(input int k, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        int dxv, dyv;
        dxv = b0[6] ? 0 : (int'(b1) - (b0[4] ? 256 : 0));
        dyv = b0[7] ? 0 : (int'(b2) - (b0[5] ? 256 : 0));
        mbtn[k] = int'(b0[2:0]);
        mdx[k]  = dxv;
        mdy[k]  = dyv;
        mwh[k]  = (k == 1) ? (int'(b3[3:0]) - (b3[3] ? 16 : 0)) : 0;
        mx[k]   = clampi(mx[k] + dxv, 639);
        my[k]   = clampi(my[k] - dyv, 479);
    endtask

    task automatic check_state(input int k, input int pv_e, input int se_e, input string tag);
        if (k == 0) begin
            chk({tag, ".pv"},  32'(pv3),  pv_e);
            chk({tag, ".se"},  32'(se3),  se_e);
            chk({tag, ".btn"}, 32'(btn3), mbtn[0]);
            chk({tag, ".dx"},  32'(dx3),  mdx[0]);
            chk({tag, ".dy"},  32'(dy3),  mdy[0]);
            chk({tag, ".wh"},  32'(wh3),  mwh[0]);
            chk({tag, ".cx"},  32'(cx3),  mx[0]);
            chk({tag, ".cy"},  32'(cy3),  my[0]);
        end else begin
            chk({tag, ".pv4"},  32'(pv4),  pv_e);
            chk({tag, ".se4"},  32'(se4),  se_e);
            chk({tag, ".btn4"}, 32'(btn4), mbtn[1]);
            chk({tag, ".dx4"},  32'(dx4),  mdx[1]);
            chk({tag, ".dy4"},  32'(dy4),  mdy[1]);
            chk({tag, ".wh4"},  32'(wh4),  mwh[1]);
            chk({tag, ".cx4"},  32'(cx4),  mx[1]);
            chk({tag, ".cy4"},  32'(cy4),  my[1]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input int k, input logic [7:0] b);
        if (k == 0) begin d3 = b; e3 = 1'b1; end
        else        begin d4 = b; e4 = 1'b1; end
        @(posedge clk);
        #1;
        e3 = 1'b0;
        e4 = 1'b0;
    endtask

    task automatic send_pkt(input int k, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input int maxgap, input bit tail);
        logic [7:0] bs [4];
        int nb;
        bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
        nb = (k == 1) ? 4 : 3;
        for (int i = 0; i < nb; i++) begin
            send_byte(k, bs[i]);
            if (i < nb - 1) begin
                check_state(k, 0, 0, "mid");
                idle(int'($urandom_range(maxgap, 0)));
            end
        end
        model_pkt(k, b0, b1, b2, b3);
        check_state(k, 1, 0, "pkt");
        if (tail) begin
            idle(1);
            check_state(k, 0, 0, "tail");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] r0, r1, r2, r3;
        rst = 1'b1; d3 = '0; d4 = '0; e3 = 1'b0; e4 = 1'b0;
        model_reset();
        idle(3);
        rst = 1'b0;
        check_state(0, 0, 0, "reset");
        check_state(1, 0, 0, "reset");

        // Basic packet and button/negative dy
        send_pkt(0, 8'h08, 8'h10, 8'h00, 8'h00, 0, 1'b1);
        chk("tp1.dx", 32'(dx3), 16);
        chk("tp1.cx", 32'(cx3), 336);
        chk("tp1.cy", 32'(cy3), 240);
        send_pkt(0, 8'h29, 8'h00, 8'hF0, 8'h00, 0, 1'b1);
        chk("tp2.btn", 32'(btn3), 1);
        chk("tp2.dy", 32'(dy3), -16);
        chk("tp2.cy", 32'(cy3), 256);

        // Move to (630,5), then clamp at both edges
        send_pkt(0, 8'h08, 8'hFF, 8'hFB, 8'h00, 0, 1'b1);
        send_pkt(0, 8'h08, 8'h27, 8'h00, 8'h00, 0, 1'b1);
        chk("tp3.pre_cx", 32'(cx3), 630);
        chk("tp3.pre_cy", 32'(cy3), 5);
        send_pkt(0, 8'h08, 8'h64, 8'h00, 8'h00, 0, 1'b1);
        chk("tp3.cx_clamp", 32'(cx3), 639);
        send_pkt(0, 8'h08, 8'h00, 8'h64, 8'h00, 0, 1'b1);
        chk("tp3.cy_clamp", 32'(cy3), 0);

        // Rejected byte 0
        send_byte(0, 8'h00);
        check_state(0, 0, 1, "bad0");
        idle(1);
        check_state(0, 0, 0, "bad0.after");
        send_pkt(0, 8'h09, 8'h00, 8'h00, 8'h00, 0, 1'b1);
        chk("tp4.btn", 32'(btn3), 1);

        // Timeout after two bytes
        send_byte(0, 8'h08);
        send_byte(0, 8'h10);
        for (int i = 0; i < T - 1; i++) begin
            idle(1);
            chk("to.wait_se", 32'(se3), 0);
        end
        idle(1);
        check_state(0, 0, 1, "timeout");
        idle(1);
        check_state(0, 0, 0, "timeout.after");
        send_pkt(0, 8'h08, 8'h05, 8'h00, 8'h00, 0, 1'b1);
        chk("tp5.dx", 32'(dx3), 5);

        // Strobe on the last timeout cycle is accepted
        send_byte(0, 8'h08);
        idle(T - 1);
        send_byte(0, 8'h03);
        check_state(0, 0, 0, "to_edge");
        send_byte(0, 8'h00);
        model_pkt(0, 8'h08, 8'h03, 8'h00, 8'h00);
        check_state(0, 1, 0, "to_edge.pkt");

        // X overflow zeroes dx
        idle(1);
        send_pkt(0, 8'h48, 8'hFF, 8'h00, 8'h00, 0, 1'b1);
        chk("tp7.dx", 32'(dx3), 0);

        // Wheel mode
        send_pkt(1, 8'h08, 8'h01, 8'h01, 8'h0F, 0, 1'b1);
        chk("tp6.wh", 32'(wh4), -1);
        chk("tp6.dx", 32'(dx4), 1);
        chk("tp6.dy", 32'(dy4), 1);

        // Reset mid-packet
        send_byte(0, 8'h08);
        send_byte(0, 8'h10);
        rst = 1'b1;
        #1;
        model_reset();
        check_state(0, 0, 0, "rst_mid");
        check_state(1, 0, 0, "rst_mid");
        idle(2);
        rst = 1'b0;
        chk("tp8.cx", 32'(cx3), 320);
        chk("tp8.cy", 32'(cy3), 240);
        send_pkt(0, 8'h08, 8'h02, 8'h00, 8'h00, 0, 1'b1);
        chk("tp8.cx_after", 32'(cx3), 322);

        // Random traffic on both instances, incl. rejects and back-to-back packets
        for (int r = 0; r < 80; r++) begin
            int k;
            k = r % 2;
            if ($urandom_range(7, 0) == 0) begin
                send_byte(k, 8'($urandom) & 8'hF7);
                check_state(k, 0, 1, "rnd.bad");
            end
            r0 = 8'($urandom) | 8'h08;
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            r3 = 8'($urandom);
            send_pkt(k, r0, r1, r2, r3, 3, 1'($urandom_range(1, 0)));
        end
        idle(2);
        check_state(0, 0, 0, "final");
        check_state(1, 0, 0, "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
